// File: rtl/qubit_gate_sequencer.sv
// Single-qubit gate sequencer: sweeps every amplitude pair of the target qubit in an
// external state-vector RAM, applies I/X/Z/Y in-line and writes the pair back in place.

module qgs_gate_alu #(
  parameter int FIXED_WIDTH = 16
) (
  input  logic [1:0]                    gate,
  input  logic signed [FIXED_WIDTH-1:0] re0,
  input  logic signed [FIXED_WIDTH-1:0] im0,
  input  logic signed [FIXED_WIDTH-1:0] re1,
  input  logic signed [FIXED_WIDTH-1:0] im1,
  output logic signed [FIXED_WIDTH-1:0] new0_re,
  output logic signed [FIXED_WIDTH-1:0] new0_im,
  output logic signed [FIXED_WIDTH-1:0] new1_re,
  output logic signed [FIXED_WIDTH-1:0] new1_im
);
  localparam logic signed [FIXED_WIDTH-1:0] MINV = {1'b1, {(FIXED_WIDTH-1){1'b0}}};
  localparam logic signed [FIXED_WIDTH-1:0] MAXV = {1'b0, {(FIXED_WIDTH-1){1'b1}}};

  // Two's-complement -MIN does not exist; clamp to MAX instead of wrapping.
  function automatic logic signed [FIXED_WIDTH-1:0] sneg(input logic signed [FIXED_WIDTH-1:0] x);
    return (x == MINV) ? MAXV : -x;
  endfunction

  always_comb begin
    new0_re = re0;
    new0_im = im0;
    new1_re = re1;
    new1_im = im1;
    case (gate)
      2'd1: begin
        new0_re = re1;
        new0_im = im1;
        new1_re = re0;
        new1_im = im0;
      end
      2'd2: begin
        new1_re = sneg(re1);
        new1_im = sneg(im1);
      end
      2'd3: begin
        new0_re = im1;
        new0_im = sneg(re1);
        new1_re = sneg(im0);
        new1_im = re0;
      end
      default: ;
    endcase
  end
endmodule

module qubit_gate_sequencer #(
  parameter int FIXED_WIDTH = 16,
  parameter int NUM_QUBITS  = 3,
  localparam int ADDR_W = NUM_QUBITS,
  localparam int TGT_W  = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_gate,
  input  logic [TGT_W-1:0]       cmd_target,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  input  logic [FIXED_WIDTH-1:0] mem_rd_real,
  input  logic [FIXED_WIDTH-1:0] mem_rd_imag,
  output logic                   mem_wr_en,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic [FIXED_WIDTH-1:0] mem_wr_real,
  output logic [FIXED_WIDTH-1:0] mem_wr_imag,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int P_W       = (NUM_QUBITS > 1) ? NUM_QUBITS - 1 : 1;
  localparam int NUM_PAIRS = 1 << (NUM_QUBITS - 1);
  localparam logic [31:0] NQ = NUM_QUBITS;

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_CALC, S_WR0, S_WR1, S_DONE
  } state_t;

  state_t state, state_n;
  logic [P_W-1:0]         p;
  logic [1:0]             gate_q;
  logic [TGT_W-1:0]       tgt_q;
  logic                   err_q;
  logic [FIXED_WIDTH-1:0] a0_re, a0_im;
  logic [FIXED_WIDTH-1:0] n0_re, n0_im, n1_re, n1_im;
  logic [FIXED_WIDTH-1:0] c0_re, c0_im, c1_re, c1_im;
  logic [ADDR_W-1:0]      pe, tbit, mask, addr0, addr1;
  logic                   tgt_ok, last_pair;

  assign tgt_ok    = (32'(cmd_target) < NQ);
  assign last_pair = (p == P_W'(NUM_PAIRS - 1));

  // Open a zero bit at the target position: bits below stay, bits above shift up.
  assign pe    = ADDR_W'(p);
  assign tbit  = ADDR_W'(1) << tgt_q;
  assign mask  = tbit - ADDR_W'(1);
  assign addr0 = ((pe & ~mask) << 1) | (pe & mask);
  assign addr1 = addr0 | tbit;

  qgs_gate_alu #(.FIXED_WIDTH(FIXED_WIDTH)) u_alu (
    .gate    (gate_q),
    .re0     (a0_re),
    .im0     (a0_im),
    .re1     (mem_rd_real),
    .im1     (mem_rd_imag),
    .new0_re (c0_re),
    .new0_im (c0_im),
    .new1_re (c1_re),
    .new1_im (c1_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (cmd_valid) state_n = tgt_ok ? S_RD0 : S_DONE;
      S_RD0:  state_n = S_RD1;
      S_RD1:  state_n = S_CALC;
      S_CALC: state_n = S_WR0;
      S_WR0:  state_n = S_WR1;
      S_WR1:  state_n = last_pair ? S_DONE : S_RD0;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p      <= '0;
      gate_q <= '0;
      tgt_q  <= '0;
      err_q  <= 1'b0;
      a0_re  <= '0;
      a0_im  <= '0;
      n0_re  <= '0;
      n0_im  <= '0;
      n1_re  <= '0;
      n1_im  <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          p      <= '0;
          gate_q <= cmd_gate;
          tgt_q  <= cmd_target;
          err_q  <= !tgt_ok;
        end
        S_RD1: begin
          a0_re <= mem_rd_real;
          a0_im <= mem_rd_imag;
        end
        S_CALC: begin
          n0_re <= c0_re;
          n0_im <= c0_im;
          n1_re <= c1_re;
          n1_im <= c1_im;
        end
        S_WR1:  p <= p + P_W'(1);
        default: ;
      endcase
    end
  end

  // All outputs decode the state register, so reset clears them asynchronously.
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign err         = (state == S_DONE) && err_q;
  assign mem_rd_en   = (state == S_RD0) || (state == S_RD1);
  assign mem_wr_en   = (state == S_WR0) || (state == S_WR1);
  assign mem_rd_addr = (state == S_RD0) ? addr0 : (state == S_RD1) ? addr1 : '0;
  assign mem_wr_addr = (state == S_WR0) ? addr0 : (state == S_WR1) ? addr1 : '0;
  assign mem_wr_real = (state == S_WR0) ? n0_re : (state == S_WR1) ? n1_re : '0;
  assign mem_wr_imag = (state == S_WR0) ? n0_im : (state == S_WR1) ? n1_im : '0;
endmodule

// File: tb/tb_qubit_gate_sequencer.sv
// Directed bench for qubit_gate_sequencer with an 8-entry amplitude RAM model.

module tb_qubit_gate_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_gate = 2'd0;
  logic [1:0]  cmd_target = 2'd0;
  logic        mem_rd_en, mem_wr_en, busy, done, err;
  logic [2:0]  mem_rd_addr, mem_wr_addr;
  logic [15:0] rd_re, rd_im, mem_wr_real, mem_wr_imag;

  qubit_gate_sequencer #(.FIXED_WIDTH(16), .NUM_QUBITS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_gate    (cmd_gate),
    .cmd_target  (cmd_target),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_real (rd_re),
    .mem_rd_imag (rd_im),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_real (mem_wr_real),
    .mem_wr_imag (mem_wr_imag),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  logic [15:0] mre [8];
  logic [15:0] mim [8];
  logic [15:0] pre_re [8];
  logic [15:0] pre_im [8];
  logic [2:0]  rd_log [16];
  logic [2:0]  wr_log [16];
  logic        load = 1'b0;
  int          rd_cnt, wr_cnt, done_cnt, both_cnt;

  // RAM model: one-cycle read latency, counters and address logs cleared on load.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++) begin
        mre[i] <= pre_re[i];
        mim[i] <= pre_im[i];
      end
      rd_re <= '0;
      rd_im <= '0;
      rd_cnt <= 0;
      wr_cnt <= 0;
      done_cnt <= 0;
      both_cnt <= 0;
    end else begin
      if (mem_rd_en) begin
        rd_re <= mre[mem_rd_addr];
        rd_im <= mim[mem_rd_addr];
        rd_log[rd_cnt[3:0]] <= mem_rd_addr;
        rd_cnt <= rd_cnt + 1;
      end
      if (mem_wr_en) begin
        mre[mem_wr_addr] <= mem_wr_real;
        mim[mem_wr_addr] <= mem_wr_imag;
        wr_log[wr_cnt[3:0]] <= mem_wr_addr;
        wr_cnt <= wr_cnt + 1;
      end
      if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_pre();
    for (int i = 0; i < 8; i++) begin
      pre_re[i] = '0;
      pre_im[i] = '0;
    end
  endtask

  task automatic preload();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic chk_mem(input int idx, input logic [15:0] re, input logic [15:0] im);
    chk($sformatf("mem%0d_re", idx), 32'(mre[idx]), 32'(re));
    chk($sformatf("mem%0d_im", idx), 32'(mim[idx]), 32'(im));
  endtask

  task automatic chk_order(input string tag, input logic [7:0][2:0] exp);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_rd"}, 32'(rd_log[i]), 32'(exp[i]));
      chk({tag, "_wr"}, 32'(wr_log[i]), 32'(exp[i]));
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rden"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_wren"}, 32'(mem_wr_en), 32'd0);
    chk({tag, "_addrs"}, {26'd0, mem_rd_addr, mem_wr_addr}, 32'd0);
    chk({tag, "_wdata"}, {mem_wr_real, mem_wr_imag}, 32'd0);
  endtask

  // Waits for done after the acceptance edge; n counts cycles after that edge.
  task automatic wait_done(input string tag, input int exp_lat, input logic exp_err);
    int  n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (done) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] g, input logic [1:0] t);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_gate = g;
    cmd_target = t;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_gate = ~g;
    cmd_target = ~t;
    wait_done(tag, 21, 1'b0);
    chk({tag, "_rdcnt"}, 32'(rd_cnt), 32'd8);
    chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'd8);
    chk({tag, "_overlap"}, 32'(both_cnt), 32'd0);
  endtask

  initial begin
    int n;
    clear_pre();
    #2;
    chk_idle_outputs("reset");
    preload();
    @(negedge clk);
    rst_n = 1'b1;

    // X on qubit 0
    clear_pre();
    pre_re[0] = 16'h4000;
    preload();
    run_cmd("x_t0", 2'd1, 2'd0);
    chk_mem(0, 16'h0000, 16'h0000);
    chk_mem(1, 16'h4000, 16'h0000);
    chk_order("x_t0", {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});

    // Z on qubit 2
    clear_pre();
    pre_re[4] = 16'h2000; pre_im[4] = 16'h1000;
    pre_re[0] = 16'h4000;
    preload();
    run_cmd("z_t2", 2'd2, 2'd2);
    chk_mem(4, 16'hE000, 16'hF000);
    chk_mem(0, 16'h4000, 16'h0000);
    chk_order("z_t2", {3'd7, 3'd3, 3'd6, 3'd2, 3'd5, 3'd1, 3'd4, 3'd0});

    // Y on qubit 1
    clear_pre();
    pre_re[0] = 16'h4000;
    pre_im[2] = 16'h2000;
    preload();
    run_cmd("y_t1", 2'd3, 2'd1);
    chk_mem(0, 16'h2000, 16'h0000);
    chk_mem(2, 16'h0000, 16'h4000);

    // Saturating negation, plus an ordinary negation on another pair
    clear_pre();
    pre_re[0] = 16'h1234; pre_im[0] = 16'h5678;
    pre_re[1] = 16'h8000; pre_im[1] = 16'h8000;
    pre_re[3] = 16'hC000; pre_im[3] = 16'h4000;
    preload();
    run_cmd("sat", 2'd2, 2'd0);
    chk_mem(0, 16'h1234, 16'h5678);
    chk_mem(1, 16'h7FFF, 16'h7FFF);
    chk_mem(3, 16'h4000, 16'hC000);

    // Invalid target with cmd_valid held, then an I command
    for (int i = 0; i < 8; i++) begin
      pre_re[i] = 16'h1100 + 16'(i);
      pre_im[i] = 16'hA000 - 16'(i);
    end
    preload();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_gate = 2'd1;
    cmd_target = 2'd3;
    @(negedge clk);
    chk("inv_done", 32'(done), 32'd1);
    chk("inv_err", 32'(err), 32'd1);
    chk("inv_rden", 32'(mem_rd_en), 32'd0);
    chk("inv_wren", 32'(mem_wr_en), 32'd0);
    chk("inv_ready", 32'(cmd_ready), 32'd0);
    cmd_gate = 2'd0;
    cmd_target = 2'd1;
    @(negedge clk);
    chk("inv_back_ready", 32'(cmd_ready), 32'd1);
    chk("inv_back_err", 32'(err), 32'd0);
    chk("inv_rdcnt", 32'(rd_cnt), 32'd0);
    chk("inv_wrcnt", 32'(wr_cnt), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done("id_t1", 21, 1'b0);
    chk("id_t1_rdcnt", 32'(rd_cnt), 32'd8);
    chk("id_t1_wrcnt", 32'(wr_cnt), 32'd8);
    chk("id_t1_donecnt", 32'(done_cnt), 32'd2);
    for (int i = 0; i < 8; i++) chk_mem(i, 16'h1100 + 16'(i), 16'hA000 - 16'(i));

    // Reset after the second pair's write-back
    clear_pre();
    pre_re[0] = 16'h4000;
    preload();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_gate = 2'd1;
    cmd_target = 2'd0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (n < 100 && wr_cnt < 4) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_wr4", 32'(wr_cnt), 32'd4);
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_wrcnt", 32'(wr_cnt), 32'd4);
    chk("midrst_donecnt", 32'(done_cnt), 32'd0);
    chk_mem(0, 16'h0000, 16'h0000);
    chk_mem(1, 16'h4000, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qubit_gate_sequencer.md
# qubit_gate_sequencer

Sequencer that applies one single-qubit gate (I, X, Y or Z) to a full state vector held in an external amplitude RAM. It accepts one command at a time, walks every amplitude pair (|..0..⟩, |..1..⟩) for the target qubit, and computes the gate in-line. It writes the results back in place and pulses `done` when the sweep is complete. It sits between the host/program controller and the state-vector memory, and drives the per-amplitude gate datapath.

## Interface
- `FIXED_WIDTH`, default 16: signed amplitude component width (two's complement, Q2.14 at default; 1.0 = 16'h4000).
- `NUM_QUBITS`, default 3: state vector holds 2^NUM_QUBITS amplitudes; `ADDR_W` = NUM_QUBITS, `TGT_W` = max(1, $clog2(NUM_QUBITS)).
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_gate`  in  2  0=I, 1=X, 2=Z, 3=Y.
- `cmd_target`  in  TGT_W  target qubit index.
- `mem_rd_en`  out  1  read strobe.
- `mem_rd_addr`  out  ADDR_W  read address.
- `mem_rd_real`, `mem_rd_imag`  in  FIXED_WIDTH each  read data, valid exactly 1 cycle after `mem_rd_en`.
- `mem_wr_en`  out  1  write strobe.
- `mem_wr_addr`  out  ADDR_W  write address.
- `mem_wr_real`, `mem_wr_imag`  out  FIXED_WIDTH each  write data.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse with `done` for an invalid target.

## Operation
- Handshake: the command is accepted on `cmd_valid && cmd_ready`. Gate and target are latched at acceptance, and input changes after acceptance are ignored.
- Pair index `p` counts 0 .. 2^(NUM_QUBITS-1)-1.
  - `addr0` = `p` with a 0 bit inserted at position `target`.
  - `addr1` = `addr0 | (1<<target)`.
- FSM: IDLE → RD0 → RD1 → CALC → WR0 → WR1 → (RD0 if more pairs, else DONE) → IDLE.
  - RD0: read `addr0`.
  - RD1: read `addr1`; capture a0.
  - CALC: capture a1.
  - WR0: write new0 to `addr0`.
  - WR1: write new1 to `addr1`; increment `p`.
  - DONE: `done`=1 for one cycle.
- Gate math (a = (re, im)):
  - I: new0=a0, new1=a1. Pairs are still written.
  - X: new0=a1, new1=a0.
  - Z: new0=a0, new1=(-re1, -im1).
  - Y: new0=(im1, -re1), new1=(-im0, re0).
- Negation saturates: -(-2^(FIXED_WIDTH-1)) = 2^(FIXED_WIDTH-1)-1. No other arithmetic is performed and there is no width growth.
- Invalid target (`cmd_target >= NUM_QUBITS`): go from IDLE directly to DONE with `done`=`err`=1. No memory access occurs.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle. Each address is read once and written once per command.

## Timing
- Reset values:
  - state=IDLE, `p`=0.
  - `cmd_ready`=1; `busy`, `done`, `err`, `mem_rd_en`, `mem_wr_en` = 0.
  - All address and data outputs = 0.
- Outputs are registered from the state. Strobes are high exactly in their named state.
- Latency: acceptance edge → RD0 next cycle. There are 5 cycles per pair. `done` is high 5·2^(NUM_QUBITS-1)+1 cycles after the acceptance edge (21 at default). `cmd_ready` returns the cycle after `done`.
- Invalid target: `done`/`err` are high the cycle after acceptance.
- `cmd_valid` held high while busy: no second acceptance until IDLE. A back-to-back command is accepted in the first IDLE cycle.
- Reset mid-operation: return to reset values immediately. No further writes are issued. Memory keeps any pairs already written; a partial sweep is acceptable.

## Test plan
- Reset: assert `rst_n`=0 mid-sweep (after the 2nd WR1) → all outputs at reset values within the same cycle. The write count stops at 4, and there is no `done`.
- X, target 0, mem[0]=(4000,0), others 0 → mem[0]=(0,0), mem[1]=(4000,0).
  - `done` is high 21 cycles after acceptance.
  - Exactly 8 reads and 8 writes, with pair order 0/1, 2/3, 4/5, 6/7.
- Z, target 2, mem[4]=(2000,1000), mem[0]=(4000,0) → mem[4]=(E000,F000); mem[0..3] are rewritten unchanged. Pair order is 0/4, 1/5, 2/6, 3/7.
- Y, target 1, mem[0]=(4000,0), mem[2]=(0,2000) → mem[0]=(2000,0), mem[2]=(0,4000).
- Saturation: Z, target 0, mem[1]=(8000,8000) → mem[1]=(7FFF,7FFF).
- Invalid target 3 with `cmd_valid` held high, followed by a valid I command → `done`+`err` pulse 1 cycle after acceptance with no memory strobes. The I command is accepted the next IDLE cycle and completes with memory unchanged and `err`=0.
